// File: rtl/stbl_trace_recorder.sv
// stbl_trace_recorder: detects qualifier-window start / stability kept / stability lost
// on a monitored word, timestamps each event and queues it for a valid/ready log reader.
module stbl_trace_recorder #(
    parameter int DATA_WIDTH = 8,
    parameter int TS_WIDTH   = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     mon_flag,
    input  logic [DATA_WIDTH-1:0]    mon_data,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [TS_WIDTH-1:0]      rec_ts,
    output logic [1:0]               rec_code,
    output logic [DATA_WIDTH-1:0]    rec_data,
    output logic [CNT_WIDTH-1:0]     rec_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = TS_WIDTH + 2 + DATA_WIDTH + CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [TS_WIDTH-1:0]   ts_q;
    logic                  last_flag_q, last_flag_d;
    logic [DATA_WIDTH-1:0] last_data_q, last_data_d;
    logic [CNT_WIDTH-1:0]  cyc_q, cyc_d;
    logic                  stable_q, stable_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;
    logic                  ovf_q, ovf_d;
    logic [RW-1:0]         mem_q [DEPTH];
    logic [AW-1:0]         wr_q, rd_q;
    logic [LW-1:0]         lvl_q, lvl_d;

    logic start, hold, fall, loss, keep, ev, full, wr_ovf, push, pop;
    logic [1:0]            ev_code;
    logic [RW-1:0]         ev_rec, push_rec, head;

    assign start   = en & mon_flag & ~last_flag_q;
    assign hold    = en & mon_flag & last_flag_q;
    assign fall    = en & ~mon_flag & last_flag_q;
    assign loss    = hold & stable_q & (mon_data != last_data_q);
    assign keep    = fall & stable_q;
    assign ev      = start | loss | keep;
    assign ev_code = start ? 2'd0 : loss ? 2'd2 : 2'd1;
    assign ev_rec  = {ts_q, ev_code, keep ? last_data_q : mon_data,
                      start ? CNT_WIDTH'(1) : cyc_q};

    // Full is judged on the pre-edge level, so a same-edge pop never frees a slot.
    assign full     = lvl_q == LW'(DEPTH);
    assign wr_ovf   = ovf_q & ~full;
    assign push     = wr_ovf | (ev & ~full);
    assign push_rec = wr_ovf ? {ts_q, 2'd3, DATA_WIDTH'(0), drop_q} : ev_rec;
    assign pop      = rec_valid & rec_ready;

    always_comb begin
        last_flag_d = en & mon_flag;
        last_data_d = en ? mon_data : last_data_q;
        cyc_d       = start ? CNT_WIDTH'(1) :
                      hold  ? (cyc_q == CNT_MAX ? cyc_q : cyc_q + CNT_WIDTH'(1)) : cyc_q;
        stable_d    = start ? 1'b1 : loss ? 1'b0 : stable_q;
        ovf_d       = wr_ovf ? ev : ovf_q | (ev & full);
        drop_d      = wr_ovf ? CNT_WIDTH'(ev) :
                      (ev & full) ? (drop_q == CNT_MAX ? drop_q : drop_q + CNT_WIDTH'(1)) : drop_q;
        lvl_d       = lvl_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q        <= '0;
            last_flag_q <= 1'b0;
            last_data_q <= '0;
            cyc_q       <= '0;
            stable_q    <= 1'b0;
            drop_q      <= '0;
            ovf_q       <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            lvl_q       <= '0;
        end else begin
            ts_q        <= ts_q + TS_WIDTH'(1);
            last_flag_q <= last_flag_d;
            last_data_q <= last_data_d;
            cyc_q       <= cyc_d;
            stable_q    <= stable_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
            wr_q        <= push ? wr_q + AW'(1) : wr_q;
            rd_q        <= pop ? rd_q + AW'(1) : rd_q;
            lvl_q       <= lvl_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_rec;
    end

    assign head       = mem_q[rd_q];
    assign rec_valid  = lvl_q != '0;
    assign fifo_level = lvl_q;
    assign {rec_ts, rec_code, rec_data, rec_count} = rec_valid ? head : '0;
endmodule

// File: doc/stbl_trace_recorder.md
Name: stbl_trace_recorder

Overview:
- Synthesizable on-chip counterpart to the bench-side stability checker and event logger: it does the recording in hardware instead of the testbench.
- Watches a qualifier `mon_flag` and a data word `mon_data`, detects window start, stability kept, and stability lost.
- Timestamps each event and queues it as a record in an internal FIFO.
- A downstream log reader drains records over a valid/ready interface.
- Sits beside a DUT interface in emulation/FPGA builds where the software testbench cannot observe.

Parameters:
- DATA_WIDTH, 8, width of monitored data and record data field
- TS_WIDTH, 16, free-running timestamp width
- CNT_WIDTH, 8, cycle-count field width (saturating)
- DEPTH, 8, FIFO entries; power of two, >=2

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  monitoring enable; when 0 no events are generated
- mon_flag  in  1  qualifier; data must be stable while high
- mon_data  in  DATA_WIDTH  monitored word
- rec_valid  out  1  FIFO head record available
- rec_ready  in  1  reader accepts head record
- rec_ts  out  TS_WIDTH  timestamp of event
- rec_code  out  2  0=START, 1=KEEP, 2=LOSS, 3=OVERFLOW
- rec_data  out  DATA_WIDTH  data field
- rec_count  out  CNT_WIDTH  cycles, or dropped-record count for OVERFLOW
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync release): ts=0, last_flag=0, last_data=0, cyc=0, stable=0, drop_cnt=0, ovf_pend=0, FIFO empty. All outputs 0.
- Timestamp: ts increments on every rising edge regardless of `en` and wraps to 0. A record carries the ts value present before that edge's increment, so the first edge after reset stamps 0.
- Edge sampling: at each edge with en=1, compare (mon_flag, mon_data) against (last_flag, last_data). last_* update every edge with en=1. With en=0, last_flag is forced to 0 and no events occur.
- START: flag=1 and last_flag=0.
  - Record {START, data=mon_data, count=1}.
  - cyc<=1, stable<=1.
- HOLD: flag=1 and last_flag=1.
  - If data!=last_data and stable=1: record {LOSS, data=mon_data, count=cyc}, then stable<=0.
  - Further changes in the same window produce no records.
  - cyc<=cyc+1, saturating at 2^CNT_WIDTH-1.
- END: flag=0 and last_flag=1.
  - If stable=1: record {KEEP, data=last_data, count=cyc}.
  - If stable=0: no record.
- At most one monitor event per edge; START, LOSS and KEEP are mutually exclusive by construction.
- FIFO write priority:
  - If ovf_pend=1 and the FIFO is not full, write {OVERFLOW, data=0, count=drop_cnt}, then clear ovf_pend and drop_cnt.
  - A monitor event in that same edge is dropped: drop_cnt<=1, ovf_pend<=1.
  - Otherwise, a monitor event is written if the FIFO is not full.
  - If the FIFO is full, the event is dropped: drop_cnt saturating +1, ovf_pend<=1.
- Full/read interaction: full is evaluated before the same-edge pop. A simultaneous pop does not free a slot that cycle.
- Latency: a record written at edge k shows rec_valid=1 in the cycle after k. Records appear in FIFO order.
- Pop handshake: a record pops when rec_valid && rec_ready at an edge.
  - rec_* stay stable while rec_valid=1 and rec_ready=0.
  - rec_ready while empty is ignored.
- Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged.
- Reset mid-operation: FIFO contents discarded, pending overflow lost, any open window forgotten. No KEEP record is emitted.

Test Plan:
- Reset, then flag high for edges ts=5..7 with data 0xA5, low at ts=8 -> records START(ts5, 0xA5, 1) and KEEP(ts8, 0xA5, 3).
- Flag high ts=2..6, data 0x11 then 0x22 at ts=4 and 0x33 at ts=5 -> START(ts2, 0x11, 1) and LOSS(ts4, 0x22, 2); no further record, no KEEP at fall.
- DEPTH=8, rec_ready=0, 6 START/KEEP pairs -> 8 stored, 4 dropped, fifo_level=8. Raise rec_ready -> 8 records drain, then OVERFLOW count=4.
- Hold rec_ready=0 with rec_valid=1 for 5 cycles -> rec_* unchanged. Toggle rec_ready every cycle -> one pop per accepted edge, order preserved.
- Flag held high 300 cycles with CNT_WIDTH=8 -> KEEP count=255. ts rolls 0xFFFF->0x0000 across a window -> stamps wrap correctly.
- Assert rst_n=0 asynchronously mid-window with 3 queued records -> rec_valid=0 and fifo_level=0 immediately. After release, no KEEP for the old window.
